// File: rtl/uart_frame_check.sv
// -----------------------------------------------------------------------------
// uart_frame_check
//
// Per-frame checker for the UART receive path. It sits behind the bit sampler
// and is driven only by the sampler's strobes. It assembles DATA_W data bits
// LSB first and accumulates parity serially. Parity is checked in one of four
// modes (even / odd / mark / space), and one or two stop bits are checked.
// Each completed frame is presented with its error flags. Saturating counters
// track how many frames had errors.
//
// Parameters
//   DATA_W        data bits per frame (5..9)
//   CNT_W         width of each saturating error counter
//
// Ports
//   clk           system clock
//   rst           synchronous, active-high reset
//   cfg_par_en    1 = parity bit present (sampled at frame_start)
//   cfg_par_typ   00 even, 01 odd, 10 mark, 11 space (sampled at frame_start)
//   cfg_stop2     1 = two stop bits (sampled at frame_start)
//   frame_start   start bit validated; begins (or restarts) a frame
//   bit_stb       sampled_bit is valid this cycle
//   sampled_bit   sampled line value
//   clr_cnt       clear both error counters (wins over an increment)
//   rx_data       assembled data of the last completed frame
//   frame_valid   one-cycle pulse, frame complete
//   par_err       parity error of the last completed frame
//   stop_err      stop error of the last completed frame
//   par_err_cnt   saturating count of frames with a parity error
//   stop_err_cnt  saturating count of frames with a stop error
// -----------------------------------------------------------------------------
module uart_frame_check #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_par_en,
    input  logic [1:0]        cfg_par_typ,
    input  logic              cfg_stop2,
    input  logic              frame_start,
    input  logic              bit_stb,
    input  logic              sampled_bit,
    input  logic              clr_cnt,
    output logic [DATA_W-1:0] rx_data,
    output logic              frame_valid,
    output logic              par_err,
    output logic              stop_err,
    output logic [CNT_W-1:0]  par_err_cnt,
    output logic [CNT_W-1:0]  stop_err_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DATA,
        S_PARITY,
        S_STOP1,
        S_STOP2,
        S_DONE
    } state_e;

    typedef enum logic [1:0] {
        PAR_EVEN  = 2'b00,
        PAR_ODD   = 2'b01,
        PAR_MARK  = 2'b10,
        PAR_SPACE = 2'b11
    } par_typ_e;

    localparam int                 BIT_CW   = $clog2(DATA_W + 1);
    localparam logic [BIT_CW-1:0]  BIT_LAST = BIT_CW'(DATA_W - 1);
    localparam logic [CNT_W-1:0]   CNT_MAX  = '1;

    state_e              state_q;
    logic                par_en_q;
    par_typ_e            par_typ_q;
    logic                stop2_q;
    logic [BIT_CW-1:0]   bit_cnt_q;
    logic                acc_q;
    logic [DATA_W-1:0]   shift_q;
    logic                par_flag_q;
    logic                stop_flag_q;

    logic [DATA_W-1:0]   rx_data_q;
    logic                frame_valid_q;
    logic                par_err_q;
    logic                stop_err_q;
    logic [CNT_W-1:0]    par_cnt_q;
    logic [CNT_W-1:0]    stop_cnt_q;

    logic                par_exp;
    logic [CNT_W-1:0]    par_cnt_d;
    logic [CNT_W-1:0]    stop_cnt_d;

    // Expected parity bit and next counter values. The counters only move on
    // the DONE cycle, so the flags from the frame that is finishing are used.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can
        // leave it unassigned and infer a latch.
        par_exp    = acc_q;
        par_cnt_d  = par_cnt_q;
        stop_cnt_d = stop_cnt_q;

        case (par_typ_q)
            PAR_EVEN:  par_exp = acc_q;
            PAR_ODD:   par_exp = ~acc_q;
            PAR_MARK:  par_exp = 1'b1;
            PAR_SPACE: par_exp = 1'b0;
            default:   par_exp = acc_q;
        endcase

        // The clear has priority over a coincident increment.
        if (clr_cnt) begin
            par_cnt_d  = '0;
            stop_cnt_d = '0;
        end else if (state_q == S_DONE) begin
            if (par_flag_q && (par_cnt_q != CNT_MAX)) begin
                par_cnt_d = par_cnt_q + CNT_W'(1);
            end
            if (stop_flag_q && (stop_cnt_q != CNT_MAX)) begin
                stop_cnt_d = stop_cnt_q + CNT_W'(1);
            end
        end
    end

    // Frame FSM with registered outputs.
    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every
        // register samples the pre-edge values and the order of statements
        // below does not create hidden dependencies.
        if (rst) begin
            state_q       <= S_IDLE;
            par_en_q      <= 1'b0;
            par_typ_q     <= PAR_EVEN;
            stop2_q       <= 1'b0;
            bit_cnt_q     <= '0;
            acc_q         <= 1'b0;
            shift_q       <= '0;
            par_flag_q    <= 1'b0;
            stop_flag_q   <= 1'b0;
            rx_data_q     <= '0;
            frame_valid_q <= 1'b0;
            par_err_q     <= 1'b0;
            stop_err_q    <= 1'b0;
            par_cnt_q     <= '0;
            stop_cnt_q    <= '0;
        end else begin
            frame_valid_q <= 1'b0;
            par_cnt_q     <= par_cnt_d;
            stop_cnt_q    <= stop_cnt_d;

            // Publish the finished frame. A frame_start on this same cycle
            // is handled below and overrides only the next state.
            if (state_q == S_DONE) begin
                frame_valid_q <= 1'b1;
                rx_data_q     <= shift_q;
                par_err_q     <= par_flag_q;
                stop_err_q    <= stop_flag_q;
                state_q       <= S_IDLE;
            end

            // frame_start wins over bit_stb in any state: the partial frame
            // is dropped and a fresh one begins with newly latched config.
            if (frame_start) begin
                par_en_q    <= cfg_par_en;
                par_typ_q   <= par_typ_e'(cfg_par_typ);
                stop2_q     <= cfg_stop2;
                bit_cnt_q   <= '0;
                acc_q       <= 1'b0;
                shift_q     <= '0;
                par_flag_q  <= 1'b0;
                stop_flag_q <= 1'b0;
                state_q     <= S_DATA;
            end else if (bit_stb) begin
                case (state_q)
                    S_DATA: begin
                        // Shift in at the MSB so the first bit ends up in bit 0.
                        shift_q   <= {sampled_bit, shift_q[DATA_W-1:1]};
                        acc_q     <= acc_q ^ sampled_bit;
                        bit_cnt_q <= bit_cnt_q + BIT_CW'(1);
                        if (bit_cnt_q == BIT_LAST) begin
                            state_q <= par_en_q ? S_PARITY : S_STOP1;
                        end
                    end
                    S_PARITY: begin
                        par_flag_q <= (sampled_bit != par_exp);
                        state_q    <= S_STOP1;
                    end
                    S_STOP1: begin
                        stop_flag_q <= ~sampled_bit;
                        state_q     <= stop2_q ? S_STOP2 : S_DONE;
                    end
                    S_STOP2: begin
                        stop_flag_q <= stop_flag_q | ~sampled_bit;
                        state_q     <= S_DONE;
                    end
                    default: begin
                        // IDLE and DONE ignore strobes.
                    end
                endcase
            end
        end
    end

    assign rx_data      = rx_data_q;
    assign frame_valid  = frame_valid_q;
    assign par_err      = par_err_q;
    assign stop_err     = stop_err_q;
    assign par_err_cnt  = par_cnt_q;
    assign stop_err_cnt = stop_cnt_q;

endmodule

// File: tb/tb_uart_frame_check.sv
// -----------------------------------------------------------------------------
// tb_uart_frame_check
//
// Directed bench for uart_frame_check (DATA_W=8, CNT_W=4). Each frame is
// driven as a start pulse followed by data, parity and stop strobes. Every
// expected value is written out by hand next to its stimulus.
// -----------------------------------------------------------------------------
module tb_uart_frame_check;

    logic       clk = 1'b0;
    logic       rst;
    logic       cfg_par_en;
    logic [1:0] cfg_par_typ;
    logic       cfg_stop2;
    logic       frame_start;
    logic       bit_stb;
    logic       sampled_bit;
    logic       clr_cnt;
    logic [7:0] rx_data;
    logic       frame_valid;
    logic       par_err;
    logic       stop_err;
    logic [3:0] par_err_cnt;
    logic [3:0] stop_err_cnt;

    int n_cmp   = 0;
    int n_bad   = 0;
    int fv_seen = 0;

    uart_frame_check #(.DATA_W(8), .CNT_W(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .cfg_par_en   (cfg_par_en),
        .cfg_par_typ  (cfg_par_typ),
        .cfg_stop2    (cfg_stop2),
        .frame_start  (frame_start),
        .bit_stb      (bit_stb),
        .sampled_bit  (sampled_bit),
        .clr_cnt      (clr_cnt),
        .rx_data      (rx_data),
        .frame_valid  (frame_valid),
        .par_err      (par_err),
        .stop_err     (stop_err),
        .par_err_cnt  (par_err_cnt),
        .stop_err_cnt (stop_err_cnt)
    );

    always #5 clk = ~clk;

    // Count frame_valid pulses to detect missing or spurious frames.
    always @(negedge clk) begin
        if (frame_valid === 1'b1) fv_seen++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Start pulse; config is scrambled right after so only the latched copy
    // can be in effect for the rest of the frame.
    task automatic start_frame(input bit pe, input logic [1:0] typ, input bit s2, input bit stb_too);
        @(posedge clk); #1;
        frame_start = 1'b1;
        cfg_par_en  = pe;
        cfg_par_typ = typ;
        cfg_stop2   = s2;
        bit_stb     = stb_too;
        sampled_bit = 1'b1;
        @(posedge clk); #1;
        frame_start = 1'b0;
        bit_stb     = 1'b0;
        cfg_par_en  = ~pe;
        cfg_par_typ = ~typ;
        cfg_stop2   = ~s2;
    endtask

    task automatic send_bit(input bit b);
        @(posedge clk); #1;
        bit_stb     = 1'b1;
        sampled_bit = b;
        @(posedge clk); #1;
        bit_stb     = 1'b0;
    endtask

    task automatic send_body(input bit pe, input logic [7:0] data, input bit parbit,
                             input bit st1, input bit s2, input bit st2);
        for (int i = 0; i < 8; i++) send_bit(data[i]);
        if (pe) send_bit(parbit);
        send_bit(st1);
        if (s2) send_bit(st2);
    endtask

    // Called right after the final stop strobe was captured. The cycle after
    // that edge is DONE (frame_valid still low); frame_valid shows one edge
    // later together with the frame results.
    task automatic finish(input string tag, input bit clr_done, input bit start_done,
                          input logic [7:0] erx, input bit epe, input bit ese,
                          input logic [3:0] epc, input logic [3:0] esc);
        @(negedge clk);
        check({tag, "_early"}, {31'd0, frame_valid}, 32'd0);
        clr_cnt = clr_done;
        if (start_done) begin
            frame_start = 1'b1;
            cfg_par_en  = 1'b1;
            cfg_par_typ = 2'b00;
            cfg_stop2   = 1'b0;
        end
        @(posedge clk); #1;
        clr_cnt     = 1'b0;
        frame_start = 1'b0;
        cfg_par_en  = 1'b0;
        cfg_par_typ = 2'b11;
        cfg_stop2   = 1'b1;
        @(negedge clk);
        check({tag, "_fv"},   {31'd0, frame_valid}, 32'd1);
        check({tag, "_rx"},   {24'd0, rx_data},     {24'd0, erx});
        check({tag, "_perr"}, {31'd0, par_err},     {31'd0, epe});
        check({tag, "_serr"}, {31'd0, stop_err},    {31'd0, ese});
        check({tag, "_pcnt"}, {28'd0, par_err_cnt}, {28'd0, epc});
        check({tag, "_scnt"}, {28'd0, stop_err_cnt},{28'd0, esc});
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rx"},   {24'd0, rx_data},      32'd0);
        check({tag, "_fv"},   {31'd0, frame_valid},  32'd0);
        check({tag, "_perr"}, {31'd0, par_err},      32'd0);
        check({tag, "_serr"}, {31'd0, stop_err},     32'd0);
        check({tag, "_pcnt"}, {28'd0, par_err_cnt},  32'd0);
        check({tag, "_scnt"}, {28'd0, stop_err_cnt}, 32'd0);
    endtask

    initial begin
        int fv_before;
        logic [3:0] exp_pc;

        rst         = 1'b1;
        cfg_par_en  = 1'b0;
        cfg_par_typ = 2'b00;
        cfg_stop2   = 1'b0;
        frame_start = 1'b0;
        bit_stb     = 1'b0;
        sampled_bit = 1'b1;
        clr_cnt     = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_all_zero("reset");

        // Even parity, 0xA5 has four ones -> parity bit 0 is correct.
        start_frame(1'b1, 2'b00, 1'b0, 1'b0);
        send_body(1'b1, 8'hA5, 1'b0, 1'b1, 1'b0, 1'b0);
        finish("even_a5", 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0, 4'd0, 4'd0);
        @(negedge clk);
        check("even_a5_pulse", {31'd0, frame_valid}, 32'd0);

        // Odd parity: 0xA5 needs parity 1, sending 0 is an error.
        start_frame(1'b1, 2'b01, 1'b0, 1'b0);
        send_body(1'b1, 8'hA5, 1'b0, 1'b1, 1'b0, 1'b0);
        finish("odd_a5", 1'b0, 1'b0, 8'hA5, 1'b1, 1'b0, 4'd1, 4'd0);

        // Odd parity: 0x01 has one 1, parity 0 is correct.
        start_frame(1'b1, 2'b01, 1'b0, 1'b0);
        send_body(1'b1, 8'h01, 1'b0, 1'b1, 1'b0, 1'b0);
        finish("odd_01", 1'b0, 1'b0, 8'h01, 1'b0, 1'b0, 4'd1, 4'd0);

        // Mark expects 1 -> error; space expects 0 -> ok.
        start_frame(1'b1, 2'b10, 1'b0, 1'b0);
        send_body(1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        finish("mark_00", 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 4'd2, 4'd0);

        start_frame(1'b1, 2'b11, 1'b0, 1'b0);
        send_body(1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        finish("space_00", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 4'd2, 4'd0);

        // No parity: frame ends after 8 data + 1 stop strobes.
        start_frame(1'b0, 2'b01, 1'b0, 1'b0);
        send_body(1'b0, 8'h3C, 1'b0, 1'b1, 1'b0, 1'b0);
        finish("nopar_3c", 1'b0, 1'b0, 8'h3C, 1'b0, 1'b0, 4'd2, 4'd0);

        // Two stop bits; 0x0F has four ones -> even parity 0.
        start_frame(1'b1, 2'b00, 1'b1, 1'b0);
        send_body(1'b1, 8'h0F, 1'b0, 1'b1, 1'b1, 1'b0);
        finish("stop2_10", 1'b0, 1'b0, 8'h0F, 1'b0, 1'b1, 4'd2, 4'd1);

        start_frame(1'b1, 2'b00, 1'b0, 1'b0);
        send_body(1'b1, 8'h0F, 1'b0, 1'b1, 1'b0, 1'b0);
        finish("stop1_ok", 1'b0, 1'b0, 8'h0F, 1'b0, 1'b0, 4'd2, 4'd1);

        start_frame(1'b1, 2'b00, 1'b1, 1'b0);
        send_body(1'b1, 8'h0F, 1'b0, 1'b0, 1'b1, 1'b1);
        finish("stop2_01", 1'b0, 1'b0, 8'h0F, 1'b0, 1'b1, 4'd2, 4'd2);

        // Clear counters while idle.
        @(posedge clk); #1 clr_cnt = 1'b1;
        @(posedge clk); #1 clr_cnt = 1'b0;
        @(negedge clk);
        check("clr_idle_pcnt", {28'd0, par_err_cnt},  32'd0);
        check("clr_idle_scnt", {28'd0, stop_err_cnt}, 32'd0);

        // 17 parity-error frames saturate the 4-bit counter at 15.
        for (int i = 0; i < 17; i++) begin
            exp_pc = (i >= 14) ? 4'd15 : 4'(i + 1);
            start_frame(1'b1, 2'b10, 1'b0, 1'b0);
            send_body(1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
            finish("sat", 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, exp_pc, 4'd0);
        end

        // clr_cnt on the DONE cycle of an errored frame: clear wins.
        start_frame(1'b1, 2'b10, 1'b0, 1'b0);
        send_body(1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        finish("clr_done", 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 4'd0, 4'd0);

        // Restart after 3 data bits; the restart pulse carries a strobe that
        // must be ignored. 0x5A has four ones -> even parity 0.
        @(posedge clk);
        fv_before = fv_seen;
        start_frame(1'b1, 2'b00, 1'b0, 1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b1);
        start_frame(1'b1, 2'b00, 1'b0, 1'b1);
        send_body(1'b1, 8'h5A, 1'b0, 1'b1, 1'b0, 1'b0);
        finish("restart_5a", 1'b0, 1'b0, 8'h5A, 1'b0, 1'b0, 4'd0, 4'd0);
        @(posedge clk);
        check("restart_count", 32'(fv_seen - fv_before), 32'd1);

        // frame_start on the DONE cycle: 0x33 completes, 0xC3 follows
        // without a separate start pulse (both have four ones).
        start_frame(1'b1, 2'b00, 1'b0, 1'b0);
        send_body(1'b1, 8'h33, 1'b0, 1'b1, 1'b0, 1'b0);
        finish("done_start_33", 1'b0, 1'b1, 8'h33, 1'b0, 1'b0, 4'd0, 4'd0);
        send_body(1'b1, 8'hC3, 1'b0, 1'b1, 1'b0, 1'b0);
        finish("done_start_c3", 1'b0, 1'b0, 8'hC3, 1'b0, 1'b0, 4'd0, 4'd0);

        // Strobes while idle are ignored; then a mark error frame on 0x81.
        @(posedge clk);
        fv_before = fv_seen;
        for (int i = 0; i < 3; i++) send_bit(1'b0);
        @(posedge clk);
        check("idle_stb_nofv", 32'(fv_seen - fv_before), 32'd0);
        start_frame(1'b1, 2'b10, 1'b0, 1'b0);
        send_body(1'b1, 8'h81, 1'b0, 1'b1, 1'b0, 1'b0);
        finish("mark_81", 1'b0, 1'b0, 8'h81, 1'b1, 1'b0, 4'd1, 4'd0);

        // Reset after 4 data strobes: everything clears, no frame appears.
        start_frame(1'b1, 2'b00, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check_all_zero("midrst");
        fv_before = fv_seen;
        for (int i = 0; i < 8; i++) send_bit(1'b1);
        repeat (4) @(posedge clk);
        check("midrst_nofv", 32'(fv_seen - fv_before), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
